// File: rtl/syrup_mem1p_responder.sv
// Single-port Syrup memory responder: one-line write-back buffer over a behavioural word array,
// stalling the initiator for a fixed penalty on every line miss.
module syrup_mem1p_responder #(
  parameter int ADDR_WIDTH    = 24,
  parameter int DATA_WIDTH    = 32,
  parameter int LINEWIDTH     = 128,
  parameter int BYTE_ENABLE   = 0,
  parameter int MEM_WORDS_LOG = 10,
  parameter int MISS_LATENCY  = 4
) (
  input  logic                    CLK,
  input  logic                    RST,
  input  logic [ADDR_WIDTH-1:0]   ADDR,
  input  logic [DATA_WIDTH-1:0]   D,
  input  logic                    WE,
  input  logic                    RE,
  input  logic [DATA_WIDTH/8-1:0] BE,
  output logic [DATA_WIDTH-1:0]   Q,
  output logic                    STALL,
  output logic [31:0]             HIT_COUNT,
  output logic [31:0]             MISS_COUNT
);

  localparam int BYTES      = DATA_WIDTH / 8;
  localparam int OFF_BITS   = $clog2(BYTES);
  localparam int LINE_WORDS = LINEWIDTH / DATA_WIDTH;
  localparam int MEM_WORDS  = 1 << MEM_WORDS_LOG;
  localparam int OW         = (LINE_WORDS > 1) ? $clog2(LINE_WORDS) : 1;
  localparam int WW         = (MISS_LATENCY > 1) ? $clog2(MISS_LATENCY) : 1;
  localparam int TW         = MEM_WORDS_LOG;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_WB   = 2'd1,
    ST_WAIT = 2'd2,
    ST_FILL = 2'd3
  } state_t;

  // The miss-detect cycle already stalls, so WAIT itself lasts MISS_LATENCY-1 cycles (skipped when 1).
  localparam state_t         AFTER_WB   = (MISS_LATENCY > 1) ? ST_WAIT : ST_FILL;
  localparam logic [WW-1:0]  WAIT_LAST  = WW'(MISS_LATENCY - 2);
  localparam logic [OW-1:0]  XFER_LAST  = OW'(LINE_WORDS - 1);

  state_t                  state_r;
  logic [DATA_WIDTH-1:0]   line_r [LINE_WORDS];
  logic [DATA_WIDTH-1:0]   mem_r  [MEM_WORDS];
  logic                    valid_r;
  logic                    dirty_r;
  logic [TW-1:0]           tag_r;
  logic [TW-1:0]           fill_tag_r;
  logic [OW-1:0]           xfer_cnt_r;
  logic [WW-1:0]           wait_cnt_r;
  logic [DATA_WIDTH-1:0]   q_r;
  logic [31:0]             hit_cnt_r;
  logic [31:0]             miss_cnt_r;

  logic [MEM_WORDS_LOG-1:0] widx_s;
  logic [TW-1:0]            req_tag_s;
  logic [OW-1:0]            req_off_s;
  logic                     req_s;
  logic                     hit_s;
  logic                     stall_s;
  logic                     unused_s;

  function automatic logic [DATA_WIDTH-1:0] be_merge(input logic [DATA_WIDTH-1:0] old_w,
                                                     input logic [DATA_WIDTH-1:0] new_w,
                                                     input logic [BYTES-1:0]      be);
    logic [DATA_WIDTH-1:0] res;
    res = old_w;
    for (int i = 0; i < BYTES; i++) begin
      if ((BYTE_ENABLE == 0) || be[i]) begin
        res[8*i +: 8] = new_w[8*i +: 8];
      end else begin
        res[8*i +: 8] = old_w[8*i +: 8];
      end
    end
    return res;
  endfunction

  function automatic logic [MEM_WORDS_LOG-1:0] word_addr(input logic [TW-1:0] tag,
                                                         input logic [OW-1:0] off);
    return MEM_WORDS_LOG'(int'(tag) * LINE_WORDS + int'(off));
  endfunction

  // Upper address bits wrap away; byte-offset bits never select anything.
  assign widx_s    = ADDR[OFF_BITS +: MEM_WORDS_LOG];
  assign req_tag_s = TW'(widx_s / LINE_WORDS);
  assign req_off_s = OW'(widx_s % LINE_WORDS);
  assign req_s     = RE | WE;
  assign hit_s     = valid_r && (tag_r == req_tag_s);
  assign stall_s   = (state_r != ST_IDLE) || (req_s && !hit_s);
  assign unused_s  = ^ADDR;

  assign Q          = q_r;
  assign STALL      = stall_s;
  assign HIT_COUNT  = hit_cnt_r;
  assign MISS_COUNT = miss_cnt_r;

  // Request service, miss sequencing and line transfers; the array and line data are never reset.
  always_ff @(posedge CLK) begin
    if (RST) begin
      state_r    <= ST_IDLE;
      valid_r    <= 1'b0;
      dirty_r    <= 1'b0;
      tag_r      <= '0;
      fill_tag_r <= '0;
      xfer_cnt_r <= '0;
      wait_cnt_r <= '0;
      q_r        <= '0;
      hit_cnt_r  <= 32'd0;
      miss_cnt_r <= 32'd0;
    end else begin
      case (state_r)
        ST_IDLE: begin
          if (req_s && hit_s) begin
            hit_cnt_r <= hit_cnt_r + 32'd1;
            if (RE) begin
              q_r <= line_r[req_off_s];
            end
            if (WE) begin
              line_r[req_off_s] <= be_merge(line_r[req_off_s], D, BE);
              dirty_r           <= 1'b1;
            end
          end else if (req_s) begin
            miss_cnt_r <= miss_cnt_r + 32'd1;
            fill_tag_r <= req_tag_s;
            xfer_cnt_r <= '0;
            wait_cnt_r <= '0;
            state_r    <= (valid_r && dirty_r) ? ST_WB : AFTER_WB;
          end
        end
        ST_WB: begin
          mem_r[word_addr(tag_r, xfer_cnt_r)] <= line_r[xfer_cnt_r];
          if (xfer_cnt_r == XFER_LAST) begin
            xfer_cnt_r <= '0;
            dirty_r    <= 1'b0;
            state_r    <= AFTER_WB;
          end else begin
            xfer_cnt_r <= xfer_cnt_r + OW'(1);
          end
        end
        ST_WAIT: begin
          if (wait_cnt_r == WAIT_LAST) begin
            wait_cnt_r <= '0;
            state_r    <= ST_FILL;
          end else begin
            wait_cnt_r <= wait_cnt_r + WW'(1);
          end
        end
        ST_FILL: begin
          line_r[xfer_cnt_r] <= mem_r[word_addr(fill_tag_r, xfer_cnt_r)];
          if (xfer_cnt_r == XFER_LAST) begin
            xfer_cnt_r <= '0;
            valid_r    <= 1'b1;
            tag_r      <= fill_tag_r;
            dirty_r    <= 1'b0;
            state_r    <= ST_IDLE;
          end else begin
            xfer_cnt_r <= xfer_cnt_r + OW'(1);
          end
        end
        default: begin
          state_r <= ST_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_syrup_mem1p_responder.sv
// Bench for syrup_mem1p_responder: directed scenarios plus random traffic against a flat-memory
// model with a line-residency tracker predicting stall lengths; two instances cover both BE modes.
module tb_syrup_mem1p_responder;

  localparam int ML = 4;
  localparam int LW = 4;

  typedef struct packed {
    logic [23:0] a;
    logic [31:0] d;
    logic        we;
    logic        re;
    logic [3:0]  be;
  } op_t;

  logic        CLK = 1'b0;
  logic        RST;
  logic [23:0] ADDR;
  logic [31:0] D;
  logic        WE;
  logic        RE;
  logic [3:0]  BE;
  logic [31:0] Q, q_be;
  logic        STALL, stall_be;
  logic [31:0] HIT_COUNT, MISS_COUNT, hit_be, miss_be;

  int n_cmp  = 0;
  int n_fail = 0;

  // model: user-visible memory contents plus which line is resident
  logic [31:0] mem_m    [int];
  logic [31:0] mem_be_m [int];
  bit          m_valid;
  bit          m_dirty;
  int          m_tag;
  int          exp_hit;
  int          exp_miss;

  syrup_mem1p_responder #(.ADDR_WIDTH(24), .DATA_WIDTH(32), .LINEWIDTH(128), .BYTE_ENABLE(0),
                          .MEM_WORDS_LOG(10), .MISS_LATENCY(ML)) dut (
    .CLK(CLK), .RST(RST), .ADDR(ADDR), .D(D), .WE(WE), .RE(RE), .BE(BE),
    .Q(Q), .STALL(STALL), .HIT_COUNT(HIT_COUNT), .MISS_COUNT(MISS_COUNT));

  syrup_mem1p_responder #(.ADDR_WIDTH(24), .DATA_WIDTH(32), .LINEWIDTH(128), .BYTE_ENABLE(1),
                          .MEM_WORDS_LOG(10), .MISS_LATENCY(ML)) dut_be (
    .CLK(CLK), .RST(RST), .ADDR(ADDR), .D(D), .WE(WE), .RE(RE), .BE(BE),
    .Q(q_be), .STALL(stall_be), .HIT_COUNT(hit_be), .MISS_COUNT(miss_be));

  always #5 CLK = ~CLK;

  function automatic void model_req(input logic [23:0] a, input logic [31:0] d, input logic we,
                                    input logic re, input logic [3:0] be, output int es,
                                    output logic kn, output logic [31:0] eq,
                                    output logic knb, output logic [31:0] eqb);
    int widx;
    int tag;
    logic [31:0] m;
    widx = int'(a >> 2) % 1024;
    tag  = widx / LW;
    es   = 0;
    if (!(m_valid && m_tag == tag)) begin
      es = ML + LW + ((m_valid && m_dirty) ? LW : 0);
      exp_miss++;
      m_valid = 1'b1;
      m_tag   = tag;
      m_dirty = 1'b0;
    end
    exp_hit++;
    kn  = mem_m.exists(widx);
    eq  = kn ? mem_m[widx] : 32'h0;
    knb = mem_be_m.exists(widx);
    eqb = knb ? mem_be_m[widx] : 32'h0;
    if (we) begin
      m_dirty     = 1'b1;
      mem_m[widx] = d;
      if (be == 4'hF) begin
        mem_be_m[widx] = d;
      end else if (knb) begin
        m = eqb;
        for (int i = 0; i < 4; i++) if (be[i]) m[8*i +: 8] = d[8*i +: 8];
        mem_be_m[widx] = m;
      end
    end
    if (!re) eq = 32'h0;
  endfunction

  task automatic drive_req(input logic [23:0] a, input logic [31:0] d, input logic we,
                           input logic re, input logic [3:0] be, output int stalls);
    ADDR = a; D = d; WE = we; RE = re; BE = be;
    stalls = 0;
    for (int k = 0; k < 64; k++) begin
      @(negedge CLK);
      if (STALL !== 1'b1) break;
      stalls++;
    end
    if (STALL === 1'b1) begin
      n_cmp++; n_fail++;
      $display("FAIL accept_timeout addr=%h: STALL still 1 after 64 cycles, want 0", a);
      stalls = -1;
    end
    @(posedge CLK); #1;
    WE = 1'b0; RE = 1'b0;
  endtask

  task automatic do_reset();
    RST = 1'b1; WE = 1'b0; RE = 1'b0;
    repeat (2) begin @(posedge CLK); #1; end
    RST = 1'b0;
    if (m_dirty) begin
      for (int k = 0; k < LW; k++) begin
        mem_m.delete(m_tag * LW + k);
        mem_be_m.delete(m_tag * LW + k);
      end
    end
    m_valid = 1'b0; m_dirty = 1'b0; exp_hit = 0; exp_miss = 0;
  endtask

  task automatic test_reset();
    do_reset();
    @(negedge CLK);
    n_cmp++; if (STALL !== 1'b0)        begin n_fail++; $display("FAIL reset_stall: got %b want 0", STALL); end
    n_cmp++; if (Q !== 32'h0)           begin n_fail++; $display("FAIL reset_q: got %h want 00000000", Q); end
    n_cmp++; if (HIT_COUNT !== 32'd0)   begin n_fail++; $display("FAIL reset_hit: got %0d want 0", HIT_COUNT); end
    n_cmp++; if (MISS_COUNT !== 32'd0)  begin n_fail++; $display("FAIL reset_miss: got %0d want 0", MISS_COUNT); end
    n_cmp++; if (q_be !== 32'h0)        begin n_fail++; $display("FAIL reset_q_be: got %h want 00000000", q_be); end
    @(posedge CLK); #1;
  endtask

  task automatic test_cold_miss();
    op_t ops [5];
    int es, st;
    logic kn, knb;
    logic [31:0] eq, eqb;
    ops = '{'{24'h000000, 32'hA5A5A5A5, 1'b1, 1'b0, 4'hF}, '{24'h000004, 32'h0BADF00D, 1'b1, 1'b0, 4'hF},
            '{24'h000008, 32'h13579BDF, 1'b1, 1'b0, 4'hF}, '{24'h00000C, 32'h2468ACE0, 1'b1, 1'b0, 4'hF},
            '{24'h000010, 32'h00000000, 1'b0, 1'b1, 4'hF}};
    for (int i = 0; i < 5; i++) begin
      model_req(ops[i].a, ops[i].d, ops[i].we, ops[i].re, ops[i].be, es, kn, eq, knb, eqb);
      drive_req(ops[i].a, ops[i].d, ops[i].we, ops[i].re, ops[i].be, st);
      n_cmp++; if (st !== es) begin n_fail++; $display("FAIL preload_stall[%0d]: got %0d want %0d", i, st, es); end
    end
    // reset keeps the array, so word0 now comes from the backing store
    do_reset();
    model_req(24'h000000, 32'h0, 1'b0, 1'b1, 4'hF, es, kn, eq, knb, eqb);
    drive_req(24'h000000, 32'h0, 1'b0, 1'b1, 4'hF, st);
    n_cmp++; if (st !== es)              begin n_fail++; $display("FAIL cold_stall: got %0d want %0d", st, es); end
    n_cmp++; if (Q !== eq)               begin n_fail++; $display("FAIL cold_q: got %h want %h", Q, eq); end
    n_cmp++; if (MISS_COUNT !== exp_miss) begin n_fail++; $display("FAIL cold_miss_cnt: got %0d want %0d", MISS_COUNT, exp_miss); end
    n_cmp++; if (HIT_COUNT !== exp_hit)  begin n_fail++; $display("FAIL cold_hit_cnt: got %0d want %0d", HIT_COUNT, exp_hit); end
  endtask

  task automatic test_sequential();
    int es, st;
    logic kn, knb;
    logic [31:0] eq, eqb, a;
    for (int i = 0; i < 4; i++) begin
      a = 32'(i * 4);
      model_req(a[23:0], 32'h0, 1'b0, 1'b1, 4'hF, es, kn, eq, knb, eqb);
      drive_req(a[23:0], 32'h0, 1'b0, 1'b1, 4'hF, st);
      n_cmp++; if (st !== es) begin n_fail++; $display("FAIL seq_stall[%0d]: got %0d want %0d", i, st, es); end
      if (kn) begin n_cmp++; if (Q !== eq) begin n_fail++; $display("FAIL seq_q[%0d]: got %h want %h", i, Q, eq); end end
    end
    n_cmp++; if (HIT_COUNT !== exp_hit)   begin n_fail++; $display("FAIL seq_hit_cnt: got %0d want %0d", HIT_COUNT, exp_hit); end
    n_cmp++; if (MISS_COUNT !== exp_miss) begin n_fail++; $display("FAIL seq_miss_cnt: got %0d want %0d", MISS_COUNT, exp_miss); end
  endtask

  task automatic test_dirty_writeback();
    op_t ops [3];
    int es, st;
    logic kn, knb;
    logic [31:0] eq, eqb;
    ops = '{'{24'h000004, 32'h11223344, 1'b1, 1'b0, 4'hF}, '{24'h000010, 32'h0, 1'b0, 1'b1, 4'hF},
            '{24'h000004, 32'h0, 1'b0, 1'b1, 4'hF}};
    for (int i = 0; i < 3; i++) begin
      model_req(ops[i].a, ops[i].d, ops[i].we, ops[i].re, ops[i].be, es, kn, eq, knb, eqb);
      drive_req(ops[i].a, ops[i].d, ops[i].we, ops[i].re, ops[i].be, st);
      n_cmp++; if (st !== es) begin n_fail++; $display("FAIL dirty_stall[%0d]: got %0d want %0d", i, st, es); end
      if (ops[i].re && kn) begin n_cmp++; if (Q !== eq) begin n_fail++; $display("FAIL dirty_q[%0d]: got %h want %h", i, Q, eq); end end
    end
    n_cmp++; if (MISS_COUNT !== exp_miss) begin n_fail++; $display("FAIL dirty_miss_cnt: got %0d want %0d", MISS_COUNT, exp_miss); end
  endtask

  task automatic test_byte_enable();
    op_t ops [3];
    int es, st;
    logic kn, knb;
    logic [31:0] eq, eqb;
    ops = '{'{24'h000000, 32'h00000000, 1'b1, 1'b0, 4'hF}, '{24'h000000, 32'hFFFFFFFF, 1'b1, 1'b0, 4'b0101},
            '{24'h000000, 32'h0, 1'b0, 1'b1, 4'hF}};
    for (int i = 0; i < 3; i++) begin
      model_req(ops[i].a, ops[i].d, ops[i].we, ops[i].re, ops[i].be, es, kn, eq, knb, eqb);
      drive_req(ops[i].a, ops[i].d, ops[i].we, ops[i].re, ops[i].be, st);
      n_cmp++; if (st !== es) begin n_fail++; $display("FAIL be_stall[%0d]: got %0d want %0d", i, st, es); end
    end
    n_cmp++; if (Q !== eq)     begin n_fail++; $display("FAIL be_off_q: got %h want %h", Q, eq); end
    n_cmp++; if (q_be !== eqb) begin n_fail++; $display("FAIL be_on_q: got %h want %h", q_be, eqb); end
  endtask

  task automatic test_rmw();
    op_t ops [3];
    int es, st;
    logic kn, knb;
    logic [31:0] eq, eqb;
    ops = '{'{24'h000008, 32'h00000005, 1'b1, 1'b0, 4'hF}, '{24'h000008, 32'h00000009, 1'b1, 1'b1, 4'hF},
            '{24'h000008, 32'h0, 1'b0, 1'b1, 4'hF}};
    for (int i = 0; i < 3; i++) begin
      model_req(ops[i].a, ops[i].d, ops[i].we, ops[i].re, ops[i].be, es, kn, eq, knb, eqb);
      drive_req(ops[i].a, ops[i].d, ops[i].we, ops[i].re, ops[i].be, st);
      n_cmp++; if (st !== es) begin n_fail++; $display("FAIL rmw_stall[%0d]: got %0d want %0d", i, st, es); end
      if (ops[i].re) begin n_cmp++; if (Q !== eq) begin n_fail++; $display("FAIL rmw_q[%0d]: got %h want %h", i, Q, eq); end end
      if (i == 1) begin n_cmp++; if (HIT_COUNT !== exp_hit) begin n_fail++; $display("FAIL rmw_hit_cnt: got %0d want %0d", HIT_COUNT, exp_hit); end end
    end
  endtask

  task automatic test_random();
    int es, st;
    logic kn, knb;
    logic [31:0] eq, eqb, r, d;
    logic [1:0] op;
    logic [3:0] be;
    logic [23:0] a;
    for (int i = 0; i < 200; i++) begin
      if ($urandom_range(0, 7) == 0) begin
        @(negedge CLK);
        n_cmp++; if (STALL !== 1'b0) begin n_fail++; $display("FAIL rnd_idle_stall[%0d]: got %b want 0", i, STALL); end
        @(posedge CLK); #1;
      end
      r  = $urandom;
      a  = {r[23:12], 5'b00000, r[6:0]};
      d  = $urandom;
      op = 2'($urandom_range(1, 3));
      be = 4'($urandom);
      model_req(a, d, op[1], op[0], be, es, kn, eq, knb, eqb);
      drive_req(a, d, op[1], op[0], be, st);
      n_cmp++; if (st !== es) begin n_fail++; $display("FAIL rnd_stall[%0d] addr=%h: got %0d want %0d", i, a, st, es); end
      if (op[0] && kn)  begin n_cmp++; if (Q !== eq)     begin n_fail++; $display("FAIL rnd_q[%0d] addr=%h: got %h want %h", i, a, Q, eq); end end
      if (op[0] && knb) begin n_cmp++; if (q_be !== eqb) begin n_fail++; $display("FAIL rnd_q_be[%0d] addr=%h: got %h want %h", i, a, q_be, eqb); end end
    end
    n_cmp++; if (HIT_COUNT !== exp_hit)   begin n_fail++; $display("FAIL rnd_hit_cnt: got %0d want %0d", HIT_COUNT, exp_hit); end
    n_cmp++; if (MISS_COUNT !== exp_miss) begin n_fail++; $display("FAIL rnd_miss_cnt: got %0d want %0d", MISS_COUNT, exp_miss); end
    n_cmp++; if (hit_be !== exp_hit)      begin n_fail++; $display("FAIL rnd_hit_cnt_be: got %0d want %0d", hit_be, exp_hit); end
    n_cmp++; if (miss_be !== exp_miss)    begin n_fail++; $display("FAIL rnd_miss_cnt_be: got %0d want %0d", miss_be, exp_miss); end
  endtask

  task automatic test_reset_mid_miss();
    int es, st;
    logic kn, knb;
    logic [31:0] eq, eqb;
    model_req(24'h000020, 32'hCAFE0020, 1'b1, 1'b0, 4'hF, es, kn, eq, knb, eqb);
    drive_req(24'h000020, 32'hCAFE0020, 1'b1, 1'b0, 4'hF, st);
    n_cmp++; if (st !== es) begin n_fail++; $display("FAIL mid_pre_stall: got %0d want %0d", st, es); end
    // dirty miss: detect cycle + LW write-back cycles, so six edges in lands inside WAIT
    ADDR = 24'h000040; RE = 1'b1; WE = 1'b0; BE = 4'hF;
    repeat (6) begin @(posedge CLK); #1; end
    n_cmp++; if (STALL !== 1'b1) begin n_fail++; $display("FAIL mid_wait_stall: got %b want 1", STALL); end
    RE = 1'b0; RST = 1'b1;
    @(posedge CLK); #1;
    RST = 1'b0;
    m_dirty = 1'b0; m_valid = 1'b0; exp_hit = 0; exp_miss = 0;
    n_cmp++; if (STALL !== 1'b0)       begin n_fail++; $display("FAIL mid_rst_stall: got %b want 0", STALL); end
    n_cmp++; if (HIT_COUNT !== 32'd0)  begin n_fail++; $display("FAIL mid_rst_hit: got %0d want 0", HIT_COUNT); end
    n_cmp++; if (MISS_COUNT !== 32'd0) begin n_fail++; $display("FAIL mid_rst_miss: got %0d want 0", MISS_COUNT); end
    n_cmp++; if (Q !== 32'h0)          begin n_fail++; $display("FAIL mid_rst_q: got %h want 00000000", Q); end
    model_req(24'h000020, 32'h0, 1'b0, 1'b1, 4'hF, es, kn, eq, knb, eqb);
    drive_req(24'h000020, 32'h0, 1'b0, 1'b1, 4'hF, st);
    n_cmp++; if (st !== es) begin n_fail++; $display("FAIL mid_wb_stall: got %0d want %0d", st, es); end
    n_cmp++; if (Q !== eq)  begin n_fail++; $display("FAIL mid_wb_q: got %h want %h", Q, eq); end
    model_req(24'h001000, 32'h0, 1'b0, 1'b1, 4'hF, es, kn, eq, knb, eqb);
    drive_req(24'h001000, 32'h0, 1'b0, 1'b1, 4'hF, st);
    n_cmp++; if (st !== es) begin n_fail++; $display("FAIL wrap_stall: got %0d want %0d", st, es); end
    if (kn)  begin n_cmp++; if (Q !== eq)     begin n_fail++; $display("FAIL wrap_q: got %h want %h", Q, eq); end end
    if (knb) begin n_cmp++; if (q_be !== eqb) begin n_fail++; $display("FAIL wrap_q_be: got %h want %h", q_be, eqb); end end
  endtask

  initial begin
    RST = 1'b1; ADDR = 24'h0; D = 32'h0; WE = 1'b0; RE = 1'b0; BE = 4'hF;
    m_valid = 1'b0; m_dirty = 1'b0; m_tag = 0; exp_hit = 0; exp_miss = 0;
    @(posedge CLK); #1;
    test_reset();
    test_cold_miss();
    test_sequential();
    test_dirty_writeback();
    test_byte_enable();
    test_rmw();
    test_random();
    test_reset_mid_miss();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

  initial begin
    #5000000;
    $display("FAIL watchdog: simulation time limit reached before completion");
    $fatal(1, "watchdog");
  end

endmodule
